// File: rtl/proj_div_seq.sv
// Perspective-projection sequencer: issues x/z and y/z to a fixed-point divider, maps quotients to screen space.
// Optional build macro PROJ_CLAMP_EN saturates offscreen coordinates instead of wrapping and flagging clip.
module proj_div_seq #(
  parameter int WIDTH    = 32,
  parameter int FBITS    = 16,
  parameter int SW       = 10,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int FOCAL    = 256
) (
  input  logic             clk,
  input  logic             rst_n,
  // vertex input
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_y,
  input  logic [WIDTH-1:0] in_z,
  // divider
  output logic             div_start,
  output logic [WIDTH-1:0] div_a,
  output logic [WIDTH-1:0] div_b,
  input  logic             div_busy,
  input  logic             div_done,
  input  logic             div_dbz,
  input  logic             div_ovf,
  input  logic [WIDTH-1:0] div_val,
  // screen vertex output
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SW-1:0]    out_sx,
  output logic [SW-1:0]    out_sy,
  output logic             out_clip
);

  localparam int W2 = 2 * WIDTH;
  localparam logic signed [W2-1:0] CX    = W2'(SCREEN_W / 2);
  localparam logic signed [W2-1:0] CY    = W2'(SCREEN_H / 2);
  localparam logic signed [W2-1:0] XMAX  = W2'(SCREEN_W - 1);
  localparam logic signed [W2-1:0] YMAX  = W2'(SCREEN_H - 1);
  localparam logic signed [W2-1:0] FOC_W = W2'(FOCAL);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIVX,
    S_WAITX,
    S_DIVY,
    S_WAITY,
    S_MAP,
    S_OUT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] z_q, z_d;
  logic [WIDTH-1:0] qx_q, qx_d;
  logic [WIDTH-1:0] qy_q, qy_d;
  logic [SW-1:0]    sx_q, sx_d;
  logic [SW-1:0]    sy_q, sy_d;
  logic             clip_q, clip_d;

  // Mapping datapath, evaluated from the latched quotients while in MAP.
  logic signed [W2-1:0] prod_x, prod_y;
  logic signed [W2-1:0] px, py;
  logic signed [W2-1:0] sx_full, sy_full;
  logic                 off_x, off_y;
  logic [SW-1:0]        sx_map, sy_map;
  logic                 clip_map;

  always_comb begin
    prod_x  = $signed(W2'($signed(qx_q))) * FOC_W;
    prod_y  = $signed(W2'($signed(qy_q))) * FOC_W;
    px      = prod_x >>> FBITS;
    py      = prod_y >>> FBITS;
    sx_full = CX + px;
    sy_full = CY - py;
    off_x   = sx_full[W2-1] || (sx_full > XMAX);
    off_y   = sy_full[W2-1] || (sy_full > YMAX);
`ifdef PROJ_CLAMP_EN
    if (sx_full[W2-1])      sx_map = '0;
    else if (sx_full > XMAX) sx_map = SW'(SCREEN_W - 1);
    else                     sx_map = sx_full[SW-1:0];
    if (sy_full[W2-1])      sy_map = '0;
    else if (sy_full > YMAX) sy_map = SW'(SCREEN_H - 1);
    else                     sy_map = sy_full[SW-1:0];
    clip_map = 1'b0;
`else
    sx_map   = sx_full[SW-1:0];
    sy_map   = sy_full[SW-1:0];
    clip_map = off_x | off_y;
`endif
  end

  // Divider operands come straight from the vertex registers, so they stay
  // stable from start until done without an extra operand stage.
  assign div_a     = ((state_q == S_DIVY) || (state_q == S_WAITY)) ? y_q : x_q;
  assign div_b     = z_q;
  assign out_valid = (state_q == S_OUT);
  assign out_sx    = sx_q;
  assign out_sy    = sy_q;
  assign out_clip  = clip_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    z_d       = z_q;
    qx_d      = qx_q;
    qy_d      = qy_q;
    sx_d      = sx_q;
    sy_d      = sy_q;
    clip_d    = clip_q;
    div_start = 1'b0;
    in_ready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Held low while reset is asserted even though the state is already IDLE.
        in_ready = rst_n;
        if (in_valid) begin
          x_d = in_x;
          y_d = in_y;
          z_d = in_z;
          if (in_z[WIDTH-1] || (in_z == '0)) begin
            sx_d    = '0;
            sy_d    = '0;
            clip_d  = 1'b1;
            state_d = S_OUT;
          end else begin
            state_d = S_DIVX;
          end
        end
      end

      S_DIVX: begin
        if (!div_busy) begin
          div_start = 1'b1;
          state_d   = S_WAITX;
        end
      end

      S_WAITX: begin
        if (div_done) begin
          if (div_dbz || div_ovf) begin
            sx_d    = '0;
            sy_d    = '0;
            clip_d  = 1'b1;
            state_d = S_OUT;
          end else begin
            qx_d    = div_val;
            state_d = S_DIVY;
          end
        end
      end

      S_DIVY: begin
        if (!div_busy) begin
          div_start = 1'b1;
          state_d   = S_WAITY;
        end
      end

      S_WAITY: begin
        if (div_done) begin
          if (div_dbz || div_ovf) begin
            sx_d    = '0;
            sy_d    = '0;
            clip_d  = 1'b1;
            state_d = S_OUT;
          end else begin
            qy_d    = div_val;
            state_d = S_MAP;
          end
        end
      end

      S_MAP: begin
        sx_d    = sx_map;
        sy_d    = sy_map;
        clip_d  = clip_map;
        state_d = S_OUT;
      end

      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      qx_q    <= '0;
      qy_q    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      clip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      qx_q    <= qx_d;
      qy_q    <= qy_d;
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      clip_q  <= clip_d;
    end
  end

endmodule

// File: tb/tb_proj_div_seq.sv
// Directed bench for proj_div_seq with a behavioural 3-cycle divider model.
// Expectations follow PROJ_CLAMP_EN when that macro is defined for the build.
module tb_proj_div_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_x, in_y, in_z;
  logic        div_start;
  logic [31:0] div_a, div_b;
  logic        div_busy, div_done, div_dbz, div_ovf;
  logic [31:0] div_val;
  logic        out_valid, out_ready;
  logic [9:0]  out_sx, out_sy;
  logic        out_clip;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // divider model state and logs
  logic        ovf_mode, stray_req;
  int          m_lat;
  logic [31:0] m_a, m_b;
  int          n_starts = 0;
  logic [31:0] a_log [0:63];
  logic [31:0] b_log [0:63];
  logic [31:0] done_a_log [0:63];
  logic [31:0] done_b_log [0:63];
  int          start_cyc [0:63];
  int          done_cyc [0:63];

  proj_div_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .in_z      (in_z),
    .div_start (div_start),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_busy  (div_busy),
    .div_done  (div_done),
    .div_dbz   (div_dbz),
    .div_ovf   (div_ovf),
    .div_val   (div_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sx    (out_sx),
    .out_sy    (out_sy),
    .out_clip  (out_clip)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] q_div(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] num, den, q;
    num = $signed({{32{a[31]}}, a}) <<< 16;
    den = $signed({{32{b[31]}}, b});
    q   = num / den;
    return q[31:0];
  endfunction

  // Divider: samples start on the clock edge, done three edges later with busy cleared.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_busy <= 1'b0;
      div_done <= 1'b0;
      div_dbz  <= 1'b0;
      div_ovf  <= 1'b0;
      div_val  <= '0;
      m_lat    <= 0;
    end else begin
      div_done <= 1'b0;
      div_ovf  <= 1'b0;
      div_dbz  <= 1'b0;
      if (stray_req) begin
        div_done <= 1'b1;
        div_val  <= 32'h1234_5678;
      end else if (div_busy) begin
        if (m_lat == 1) begin
          div_busy <= 1'b0;
          div_done <= 1'b1;
          div_ovf  <= ovf_mode;
          div_val  <= ovf_mode ? 32'h7FFF_FFFF : q_div(m_a, m_b);
          done_cyc[n_starts-1]   <= cyc + 1;
          done_a_log[n_starts-1] <= div_a;
          done_b_log[n_starts-1] <= div_b;
        end
        m_lat <= m_lat - 1;
      end else if (div_start) begin
        div_busy <= 1'b1;
        m_lat    <= 3;
        m_a      <= div_a;
        m_b      <= div_b;
        a_log[n_starts]     <= div_a;
        b_log[n_starts]     <= div_b;
        start_cyc[n_starts] <= cyc;
        n_starts <= n_starts + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Drives one vertex, holds out_ready low for `hold` cycles of out_valid, then completes the handshake.
  task automatic run_vertex(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                            input int hold, output logic [9:0] sx, output logic [9:0] sy,
                            output logic clip, output int acc_c, output int ov_c);
    int n;
    @(negedge clk);
    in_x = x; in_y = y; in_z = z; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check("in_ready_idle", in_ready, 1);
    acc_c = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    check("in_ready_after_accept", in_ready, 0);
    n = 0;
    while (!out_valid && n < 200) begin @(negedge clk); n++; end
    check("out_valid_timeout", out_valid, 1);
    ov_c = cyc; sx = out_sx; sy = out_sy; clip = out_clip;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_sx_stable", out_sx, sx);
      check("bp_sy_stable", out_sy, sy);
      check("bp_clip_stable", out_clip, clip);
      check("bp_in_ready", in_ready, 0);
      check("bp_div_start", div_start, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_out", in_ready, 1);
    check("out_valid_after_out", out_valid, 0);
  endtask

  // Checks a completed two-division vertex: operands, handshake latencies and count.
  task automatic check_two_div(input string tag, input int base, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] z, input int acc_c, input int ov_c);
    check({tag, "_nstart"}, n_starts - base, 2);
    check({tag, "_a_x"}, a_log[base], x);
    check({tag, "_b_x"}, b_log[base], z);
    check({tag, "_a_y"}, a_log[base+1], y);
    check({tag, "_b_y"}, b_log[base+1], z);
    check({tag, "_a_x_held"}, done_a_log[base], x);
    check({tag, "_b_y_held"}, done_b_log[base+1], z);
    check({tag, "_lat_accept_start"}, start_cyc[base] - acc_c, 1);
    check({tag, "_lat_done_start"}, start_cyc[base+1] - done_cyc[base], 1);
    check({tag, "_lat_done_out"}, ov_c - done_cyc[base+1], 2);
  endtask

  initial begin
    logic [9:0] sx, sy;
    logic       clip;
    int         acc_c, ov_c, base, n;

    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_z = '0;
    out_ready = 1'b0; ovf_mode = 1'b0; stray_req = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_div_start", div_start, 0);
    check("rst_div_a", div_a, 0);
    check("rst_div_b", div_b, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sx", out_sx, 0);
    check("rst_out_sy", out_sy, 0);
    check("rst_out_clip", out_clip, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // nominal: 0.5*256 = 128 -> 448; 0.25*256 = 64 -> 176
    base = n_starts;
    run_vertex(32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 0, sx, sy, clip, acc_c, ov_c);
    check("nom_sx", sx, 448);
    check("nom_sy", sy, 176);
    check("nom_clip", clip, 0);
    check_two_div("nom", base, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, acc_c, ov_c);

    // near-plane rejects: z = 0 and z = -1.0
    base = n_starts;
    run_vertex(32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 0, sx, sy, clip, acc_c, ov_c);
    check("z0_nstart", n_starts - base, 0);
    check("z0_lat", ov_c - acc_c, 1);
    check("z0_sx", sx, 0);
    check("z0_sy", sy, 0);
    check("z0_clip", clip, 1);
    base = n_starts;
    run_vertex(32'h0001_0000, 32'h0001_0000, 32'hFFFF_0000, 0, sx, sy, clip, acc_c, ov_c);
    check("zneg_nstart", n_starts - base, 0);
    check("zneg_lat", ov_c - acc_c, 1);
    check("zneg_sx", sx, 0);
    check("zneg_sy", sy, 0);
    check("zneg_clip", clip, 1);

    // offscreen: px = 2560 -> sx_full = 2880
    base = n_starts;
    run_vertex(32'h000A_0000, 32'h0000_0000, 32'h0001_0000, 0, sx, sy, clip, acc_c, ov_c);
`ifdef PROJ_CLAMP_EN
    check("off_sx", sx, 639);
    check("off_sy", sy, 240);
    check("off_clip", clip, 0);
`else
    check("off_sx", sx, 832);
    check("off_sy", sy, 240);
    check("off_clip", clip, 1);
`endif
    check("off_nstart", n_starts - base, 2);

    // divider overflow on the x division: y division skipped
    ovf_mode = 1'b1;
    base = n_starts;
    run_vertex(32'h7FFF_0000, 32'h0000_0000, 32'h0000_0100, 0, sx, sy, clip, acc_c, ov_c);
    ovf_mode = 1'b0;
    check("ovf_nstart", n_starts - base, 1);
    check("ovf_sx", sx, 0);
    check("ovf_sy", sy, 0);
    check("ovf_clip", clip, 1);

    // backpressure: out_ready low for 5 cycles, accepted on the 6th
    base = n_starts;
    run_vertex(32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 5, sx, sy, clip, acc_c, ov_c);
    check("bp_sx", sx, 448);
    check("bp_sy", sy, 176);
    check("bp_clip", clip, 0);
    check("bp_nstart", n_starts - base, 2);

    // reset while waiting on the x division
    base = n_starts;
    @(negedge clk);
    in_x = 32'h0001_0000; in_y = 32'h0000_8000; in_z = 32'h0002_0000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!div_busy && n < 20) begin @(negedge clk); n++; end
    check("mid_reach_waitx", div_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_div_start", div_start, 0);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    check("mid_rst_div_start2", div_start, 0);
    check("mid_rst_out_valid2", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    stray_req = 1'b1;
    @(negedge clk);
    stray_req = 1'b0;
    check("stray_in_ready", in_ready, 1);
    check("stray_div_start", div_start, 0);
    @(negedge clk);
    check("stray_after_in_ready", in_ready, 1);
    check("stray_after_out_valid", out_valid, 0);
    check("stray_after_div_start", div_start, 0);
    check("mid_nstart", n_starts - base, 1);

    base = n_starts;
    run_vertex(32'h0001_0000, 32'h0000_8000, 32'h0002_0000, 0, sx, sy, clip, acc_c, ov_c);
    check("post_sx", sx, 448);
    check("post_sy", sy, 176);
    check("post_clip", clip, 0);
    check_two_div("post", base, 32'h0001_0000, 32'h0000_8000, 32'h0002_0000, acc_c, ov_c);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/proj_div_seq.md
# proj_div_seq

Perspective-projection sequencer sitting directly upstream of the signed fixed-point divider in the vertex path. It accepts one view-space vertex (x, y, z) over a valid/ready handshake and issues two divisions, x/z then y/z, through the divider's start/done handshake. It maps the quotients to integer screen coordinates and presents them, with a clip flag, over a valid/ready output to the rasteriser setup stage.

## Interface
- WIDTH, 32: word width of x, y, z and divider operands/result (Q format, signed)
- FBITS, 16: fractional bits; must equal the divider's FBITS
- SW, 10: screen-coordinate output width (unsigned)
- SCREEN_W, 640: screen width in pixels; CX = SCREEN_W/2
- SCREEN_H, 480: screen height in pixels; CY = SCREEN_H/2
- FOCAL, 256: focal length in pixels (integer, 1..2^(WIDTH-2))

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  vertex available
- in_ready  out  1  block can accept a vertex
- in_x, in_y, in_z  in  WIDTH each  signed Q vertex coordinates
- div_start  out  1  one-cycle start pulse to divider
- div_a, div_b  out  WIDTH each  dividend/divisor, held stable from start until done
- div_busy, div_done, div_dbz, div_ovf  in  1 each  divider status
- div_val  in  WIDTH  divider quotient
- out_valid  out  1  screen vertex available
- out_ready  in  1  downstream accepts
- out_sx, out_sy  out  SW each  screen coordinates
- out_clip  out  1  vertex rejected/off-screen

## Operation
- States: IDLE, DIVX, WAITX, DIVY, WAITY, MAP, OUT.
- IDLE: in_ready=1. On in_valid: register x, y, z.
  - If z <= 0 (sign set or zero): go to OUT with clip=1, sx=sy=0. No division is issued.
  - Otherwise go to DIVX.
- DIVX/DIVY: drive div_a=x (or y), div_b=z. Pulse div_start for one cycle only when div_busy=0, then move to WAITX/WAITY. If div_busy=1, hold in DIVX/DIVY.
- WAITX/WAITY: wait for div_done.
  - div_dbz or div_ovf on done: go to OUT with clip=1, sx=sy=0. The y division is skipped.
  - Otherwise latch qx (or qy) = div_val.
- MAP: compute in 2*WIDTH signed arithmetic:
  - px = (qx*FOCAL) >>> FBITS, arithmetic shift (floor)
  - sx_full = CX + px
  - sy_full = CY - ((qy*FOCAL) >>> FBITS), screen y grows downward
  - Offscreen if sx_full outside [0, SCREEN_W-1] or sy_full outside [0, SCREEN_H-1].
- OUT: out_valid=1. Outputs are held stable until out_ready; on out_valid&out_ready go to IDLE.
- div_done seen in any state other than WAITX/WAITY is ignored.

## Timing
- Reset values: in_ready=0 during reset, 1 after release (IDLE). div_start=0, div_a=div_b=0, out_valid=0, out_sx=out_sy=0, out_clip=0.
- Reset mid-operation returns to IDLE immediately. The in-flight division's result is discarded.
- Own overhead per vertex, with divider idle:
  - accept → div_start(x): 1 cycle
  - div_done(x) → div_start(y): 1 cycle
  - div_done(y) → out_valid: 2 cycles (MAP, OUT)
- z <= 0 reject: out_valid 1 cycle after accept.
- Throughput: one vertex in flight. in_ready=0 from the accept cycle until the OUT handshake completes. In IDLE, in_ready=1 combinationally with no bubble after out handshake.

## Configuration
- PROJ_CLAMP_EN defined:
  - Offscreen sx/sy are saturated to [0, SCREEN_W-1] / [0, SCREEN_H-1].
  - out_clip is set only for z <= 0, dbz or ovf.
- PROJ_CLAMP_EN undefined:
  - out_sx/out_sy are the low SW bits of sx_full/sy_full (wrap).
  - out_clip is additionally set when the vertex is offscreen.

## Test plan
- Nominal: x=0x00010000, y=0x00008000, z=0x00020000 → two div_start pulses (a=x,b=z; a=y,b=z); out_sx=448, out_sy=176, out_clip=0.
- Near-plane reject: z=0, then z=0xFFFF0000 → no div_start; out_valid 1 cycle after accept; sx=sy=0, clip=1.
- Offscreen: x=0x000A0000, y=0, z=0x00010000 → with PROJ_CLAMP_EN sx=639, sy=240, clip=0. Without it sx=832 (2880 mod 1024), sy=240, clip=1.
- Divider overflow: x=0x7FFF0000, z=0x00000100 with div_ovf returned → exactly one div_start; clip=1, sx=sy=0.
- Backpressure: out_ready low 5 cycles after out_valid → out_* stable, in_ready=0, no div_start. Accept on cycle 6, then in_ready=1.
- Reset mid-WAITX: rst_n low 2 cycles → div_start=0, out_valid=0. After release, a stray div_done is ignored. The next vertex completes with correct values.
